// File: rtl/symbol_buffer_if.sv
// Editor/plot handshake bundle for symbol_buffer.
// master = editor and plotting logic, slave = the buffer itself.
interface symbol_buffer_if #(
    parameter int SYMBOL_WIDTH = 7,
    parameter int LENGTH_WIDTH = 7
);
    logic                    wr_en;
    logic [SYMBOL_WIDTH-1:0] wr_symbol;
    logic                    bs_en;
    logic                    clr_en;
    logic                    rewind;
    logic                    symbol_iter_en;
    logic [SYMBOL_WIDTH-1:0] symbol;
    logic                    symbol_valid;
    logic                    busy;
    logic [LENGTH_WIDTH-1:0] length;
    logic                    full;
    logic                    empty;

    modport master (
        output wr_en, wr_symbol, bs_en, clr_en, rewind, symbol_iter_en,
        input  symbol, symbol_valid, busy, length, full, empty
    );

    modport slave (
        input  wr_en, wr_symbol, bs_en, clr_en, rewind, symbol_iter_en,
        output symbol, symbol_valid, busy, length, full, empty
    );
endinterface

// File: rtl/symbol_buffer.sv
// Expression text buffer streaming stored symbols plus one terminator to the plotter.
// Optional macro SYMBOL_BUFFER_FILTER_EN: drop non-printable writes (< 0x20 or 0x7F).
module symbol_buffer #(
    parameter int                   SYMBOL_WIDTH = 7,
    parameter int                   MAX_LENGTH   = 64,
    parameter logic [SYMBOL_WIDTH-1:0] END_SYMBOL = 7'h20,
    parameter int                   LENGTH_WIDTH = $clog2(MAX_LENGTH + 1)
) (
    input logic            clk,
    input logic            rst,
    symbol_buffer_if.slave bus
);
    localparam int ADDR_WIDTH = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
    localparam logic [LENGTH_WIDTH-1:0] MAX_LEN_C = LENGTH_WIDTH'(MAX_LENGTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_TERM   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [LENGTH_WIDTH-1:0] idx_q, idx_d;
    logic [LENGTH_WIDTH-1:0] len_q, len_d;
    logic [LENGTH_WIDTH-1:0] idx_inc_s;
    logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;
    logic                    vld_q, vld_d;
    logic [SYMBOL_WIDTH-1:0] mem_q [MAX_LENGTH];

    logic busy_s;
    logic full_s;
    logic empty_s;
    logic edit_ok_s;
    logic storable_s;
    logic mem_we_s;

    assign busy_s    = (state_q != ST_IDLE);
    assign full_s    = (len_q == MAX_LEN_C);
    assign empty_s   = (len_q == LENGTH_WIDTH'(0));
    assign idx_inc_s = idx_q + LENGTH_WIDTH'(1);
    // Length is frozen while iterating, so STREAM can trust idx < len.
    assign edit_ok_s = !busy_s && !bus.rewind;

    // Decide whether the offered symbol is allowed into storage.
    always_comb begin
        storable_s = 1'b1;
`ifdef SYMBOL_BUFFER_FILTER_EN
        storable_s = (bus.wr_symbol >= SYMBOL_WIDTH'(32)) &&
                     (bus.wr_symbol != SYMBOL_WIDTH'(127));
`else
        storable_s = 1'b1;
`endif
    end

    // Iteration FSM: next state, read index and registered symbol/strobe.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sym_d   = sym_q;
        vld_d   = 1'b0;
        if (bus.rewind) begin
            idx_d   = LENGTH_WIDTH'(0);
            state_d = empty_s ? ST_TERM : ST_STREAM;
        end else begin
            case (state_q)
                ST_STREAM: begin
                    if (bus.symbol_iter_en) begin
                        sym_d   = mem_q[idx_q[ADDR_WIDTH-1:0]];
                        vld_d   = 1'b1;
                        idx_d   = idx_inc_s;
                        state_d = (idx_inc_s == len_q) ? ST_TERM : ST_STREAM;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
                ST_TERM: begin
                    if (bus.symbol_iter_en) begin
                        sym_d   = END_SYMBOL;
                        vld_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_TERM;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Editor commands: clear beats backspace beats append.
    always_comb begin
        len_d    = len_q;
        mem_we_s = 1'b0;
        if (edit_ok_s) begin
            if (bus.clr_en) begin
                len_d = LENGTH_WIDTH'(0);
            end else if (bus.bs_en) begin
                if (!empty_s) begin
                    len_d = len_q - LENGTH_WIDTH'(1);
                end else begin
                    len_d = len_q;
                end
            end else if (bus.wr_en) begin
                if (!full_s && storable_s) begin
                    mem_we_s = 1'b1;
                    len_d    = len_q + LENGTH_WIDTH'(1);
                end else begin
                    len_d = len_q;
                end
            end else begin
                len_d = len_q;
            end
        end else begin
            len_d = len_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= LENGTH_WIDTH'(0);
            len_q   <= LENGTH_WIDTH'(0);
            sym_q   <= SYMBOL_WIDTH'(0);
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            sym_q   <= sym_d;
            vld_q   <= vld_d;
        end
    end

    // Symbol storage; contents are meaningless beyond len_q so no reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[len_q[ADDR_WIDTH-1:0]] <= bus.wr_symbol;
        end
    end

    assign bus.symbol       = sym_q;
    assign bus.symbol_valid = vld_q;
    assign bus.busy         = busy_s;
    assign bus.length       = len_q;
    assign bus.full         = full_s;
    assign bus.empty        = empty_s;

endmodule

// File: tb/tb_symbol_buffer.sv
// Randomised + directed bench for symbol_buffer against a queue-based reference model.
module tb_symbol_buffer;
    localparam int SW = 7;
    localparam int ML = 64;
    localparam int LW = 7;
    localparam logic [6:0] END_C = 7'h20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    symbol_buffer_if #(.SYMBOL_WIDTH(SW), .LENGTH_WIDTH(LW)) bus ();

    symbol_buffer #(
        .SYMBOL_WIDTH(SW), .MAX_LENGTH(ML), .END_SYMBOL(END_C), .LENGTH_WIDTH(LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: stored text as a queue, iteration as a position into it.
    logic [6:0] m_text[$];
    bit         m_busy;
    int         m_pos;
    logic [6:0] m_sym;
    bit         m_vld;
    logic [6:0] dut_str[$];

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit w, input logic [6:0] ws, input bit b,
                         input bit c, input bit rw, input bit it);
        bit was_busy;
        bit ok;
        rst                = r;
        bus.wr_en          = w;
        bus.wr_symbol      = ws;
        bus.bs_en          = b;
        bus.clr_en         = c;
        bus.rewind         = rw;
        bus.symbol_iter_en = it;
        @(posedge clk);
        if (r) begin
            m_text.delete();
            m_busy = 0; m_pos = 0; m_sym = 7'h00; m_vld = 0;
        end else begin
            was_busy = m_busy;
            m_vld = 0;
            if (rw) begin
                m_busy = 1; m_pos = 0;
            end else if (m_busy && it) begin
                m_vld = 1;
                if (m_pos < m_text.size()) begin
                    m_sym = m_text[m_pos];
                    m_pos++;
                end else begin
                    m_sym = END_C;
                    m_busy = 0;
                end
            end
            if (!was_busy && !rw) begin
                if (c) m_text.delete();
                else if (b) begin
                    if (m_text.size() > 0) void'(m_text.pop_back());
                end else if (w) begin
                    ok = 1;
`ifdef SYMBOL_BUFFER_FILTER_EN
                    ok = (ws >= 7'h20) && (ws != 7'h7F);
`endif
                    if (ok && m_text.size() < ML) m_text.push_back(ws);
                end
            end
        end
        #1;
        expect_eq("symbol_valid", {31'd0, bus.symbol_valid}, {31'd0, m_vld});
        expect_eq("symbol", {25'd0, bus.symbol}, {25'd0, m_sym});
        expect_eq("busy", {31'd0, bus.busy}, {31'd0, m_busy});
        expect_eq("length", {25'd0, bus.length}, m_text.size());
        expect_eq("full", {31'd0, bus.full}, {31'd0, (m_text.size() == ML)});
        expect_eq("empty", {31'd0, bus.empty}, {31'd0, (m_text.size() == 0)});
        if (bus.symbol_valid) dut_str.push_back(bus.symbol);
    endtask

    task automatic idle(input bit it);
        cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, it);
    endtask

    task automatic put(input logic [6:0] s);
        cycle(1'b0, 1'b1, s, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_rewind();
        cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_clear();
        cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bit r, w, b, c, rw, it;
        // Reset state
        cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_eq("reset_empty", {31'd0, bus.empty}, 32'd1);

        // "1+x" streamed back-to-back with terminator
        put(7'h31); put(7'h2B); put(7'h78);
        do_rewind();
        dut_str.delete();
        for (int i = 0; i < 4; i++) idle(1'b1);
        expect_eq("p1_count", dut_str.size(), 32'd4);
        if (dut_str.size() == 4) begin
            expect_eq("p1_s0", {25'd0, dut_str[0]}, 32'h31);
            expect_eq("p1_s1", {25'd0, dut_str[1]}, 32'h2B);
            expect_eq("p1_s2", {25'd0, dut_str[2]}, 32'h78);
            expect_eq("p1_s3", {25'd0, dut_str[3]}, 32'h20);
        end
        expect_eq("p1_busy_done", {31'd0, bus.busy}, 32'd0);
        expect_eq("p1_len", {25'd0, bus.length}, 32'd3);

        // Empty buffer gives exactly one terminator
        do_clear();
        do_rewind();
        dut_str.delete();
        for (int i = 0; i < 11; i++) idle(1'b1);
        expect_eq("p2_count", dut_str.size(), 32'd1);
        if (dut_str.size() == 1) expect_eq("p2_sym", {25'd0, dut_str[0]}, 32'h20);

        // Fill past capacity, then backspace past empty
        for (int i = 0; i < ML + 1; i++) put(7'($urandom_range(33, 126)));
        expect_eq("p3_full", {31'd0, bus.full}, 32'd1);
        expect_eq("p3_len64", {25'd0, bus.length}, 32'd64);
        for (int i = 0; i < ML + 1; i++) cycle(1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_eq("p3_len0", {25'd0, bus.length}, 32'd0);
        expect_eq("p3_empty", {31'd0, bus.empty}, 32'd1);

        // Gapped enables
        put(7'h31); put(7'h32);
        do_rewind();
        dut_str.delete();
        idle(1'b1); idle(1'b0); idle(1'b1); idle(1'b0);
        expect_eq("p4_count", dut_str.size(), 32'd2);
        idle(1'b1); idle(1'b0);
        expect_eq("p4_count_term", dut_str.size(), 32'd3);
        if (dut_str.size() == 3) expect_eq("p4_term", {25'd0, dut_str[2]}, 32'h20);

        // Edits while busy are dropped; rewind restarts
        do_clear();
        put(7'h31); put(7'h32);
        do_rewind();
        idle(1'b1);
        put(7'h7A);
        cycle(1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        do_clear();
        expect_eq("p5_len", {25'd0, bus.length}, 32'd2);
        do_rewind();
        idle(1'b1);
        expect_eq("p5_restart", {25'd0, bus.symbol}, 32'h31);
        idle(1'b1); idle(1'b1);

        // Control-character write
        do_clear();
        put(7'h0A); put(7'h41);
`ifdef SYMBOL_BUFFER_FILTER_EN
        expect_eq("p6_len", {25'd0, bus.length}, 32'd1);
`else
        expect_eq("p6_len", {25'd0, bus.length}, 32'd2);
`endif
        do_rewind();
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Random traffic including mid-iteration resets
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            w  = ($urandom_range(0, 99) < 45);
            b  = ($urandom_range(0, 99) < 10);
            c  = ($urandom_range(0, 99) < 2);
            rw = ($urandom_range(0, 99) < 4);
            it = ($urandom_range(0, 99) < 60);
            cycle(r, w, 7'($urandom), b, c, rw, it);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
